// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic cells.
// Holds the controller state encoding and the bit-counter width rule.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A 1-bit operand still needs a 1-bit counter, hence the floor of one.
   function automatic int cnt_width(input int w);
      return ($clog2(w) < 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
// Purely combinational: zero latency, no flow control.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic h1_s;
   logic h1_c;
   logic h2_c;

   assign h1_s = a ^ b;
   assign h1_c = a & b;
   assign s    = h1_s ^ cin;
   assign h2_c = h1_s & cin;
   assign cout = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one full-adder cell plus a carry flop.
// Result WIDTH cycles after the accepting edge; start is ignored while busy.
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_width(int'(WIDTH));

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             fa_s;
   logic             fa_c;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] sr_next;

   full_adder_cell u_fa (
      .a    (sa_q[0]),
      .b    (sb_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_c)
   );

   assign accept  = start && ((state_q == IDLE) || (state_q == DONE));
   assign last    = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
   // New bit enters at the MSB so after WIDTH shifts bit 0 lands at position 0.
   assign sr_next = (sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? RUN : IDLE;
         RUN:     state_d = last ? DONE : RUN;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   always_comb begin
      sa_d    = sa_q;
      sb_d    = sb_q;
      sr_d    = sr_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (accept) begin
         sa_d    = a;
         sb_d    = b;
         sr_d    = '0;
         carry_d = cin;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         sa_d    = sa_q >> 1;
         sb_d    = sb_q >> 1;
         sr_d    = sr_next;
         carry_d = fa_c;
         if (last) begin
            sum_d  = sr_next;
            cout_d = fa_c;
         end else begin
            cnt_d  = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa_q    <= '0;
         sb_q    <= '0;
         sr_q    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sr_q    <= sr_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Expected results come from plain integer addition of the operands.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       s8_start, s8_cin, s8_busy, s8_done, s8_cout;
   logic [7:0] s8_a, s8_b, s8_sum;
   logic       s1_start, s1_cin, s1_busy, s1_done, s1_cout;
   logic [0:0] s1_a, s1_b, s1_sum;

   int n_cmp = 0;
   int n_bad = 0;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (s8_start),
      .a     (s8_a),
      .b     (s8_b),
      .cin   (s8_cin),
      .busy  (s8_busy),
      .done  (s8_done),
      .sum   (s8_sum),
      .cout  (s8_cout)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (s1_start),
      .a     (s1_a),
      .b     (s1_b),
      .cin   (s1_cin),
      .busy  (s1_busy),
      .done  (s1_done),
      .sum   (s1_sum),
      .cout  (s1_cout)
   );

   // Issues one WIDTH=8 operation and waits (bounded) for its done pulse.
   // lat counts rising edges from the accepting edge to the done cycle; -1 on timeout.
   task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         output logic [7:0] s, output logic co, output int lat, output int bcnt);
      @(negedge clk);
      s8_a = a; s8_b = b; s8_cin = c; s8_start = 1'b1;
      lat = -1; bcnt = 0; s = 8'h00; co = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) begin
            s8_start = 1'b0;
            s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom);
         end
         if (s8_busy) bcnt++;
         if (s8_done) begin
            lat = k - 1; s = s8_sum; co = s8_cout;
            break;
         end
      end
   endtask

   task automatic do_op1(input logic a, input logic b, input logic c,
                         output logic s, output logic co, output int lat, output int bcnt);
      @(negedge clk);
      s1_a = a; s1_b = b; s1_cin = c; s1_start = 1'b1;
      lat = -1; bcnt = 0; s = 1'b0; co = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) s1_start = 1'b0;
         if (s1_busy) bcnt++;
         if (s1_done) begin
            lat = k - 1; s = s1_sum[0]; co = s1_cout;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      s8_start = 1'b0; s8_a = 8'h00; s8_b = 8'h00; s8_cin = 1'b0;
      s1_start = 1'b0; s1_a = 1'b0; s1_b = 1'b0; s1_cin = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({s8_busy, s8_done, s8_cout, s8_sum} !== 11'h000) begin
         n_bad++;
         $display("FAIL reset8 busy/done/cout/sum got=%b/%b/%b/%h want 0/0/0/00", s8_busy, s8_done, s8_cout, s8_sum);
      end
      n_cmp++;
      if ({s1_busy, s1_done, s1_cout, s1_sum} !== 4'h0) begin
         n_bad++;
         $display("FAIL reset1 busy/done/cout/sum got=%b/%b/%b/%b want 0/0/0/0", s1_busy, s1_done, s1_cout, s1_sum);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [7:0] s; logic co; int lat, bc;
      do_op8(8'h0F, 8'h01, 1'b0, s, co, lat, bc);
      n_cmp++;
      if (lat !== 8) begin n_bad++; $display("FAIL basic_latency got=%0d want 8", lat); end
      n_cmp++;
      if (bc !== 8) begin n_bad++; $display("FAIL basic_busy_cycles got=%0d want 8", bc); end
      n_cmp++;
      if ({co, s} !== 9'h010) begin n_bad++; $display("FAIL basic_result got=%b/%h want 0/10", co, s); end
      @(negedge clk);
      n_cmp++;
      if (s8_done !== 1'b0 || s8_busy !== 1'b0) begin
         n_bad++; $display("FAIL basic_done_width done=%b busy=%b want 0/0", s8_done, s8_busy);
      end
      n_cmp++;
      if (s8_sum !== 8'h10) begin n_bad++; $display("FAIL basic_sum_hold got=%h want 10", s8_sum); end
   endtask

   task automatic test_carry_edges;
      logic [7:0] s; logic co; int lat, bc;
      do_op8(8'hFF, 8'h01, 1'b0, s, co, lat, bc);
      n_cmp++;
      if ({co, s} !== 9'h100) begin n_bad++; $display("FAIL wrap_ff01 got=%b/%h want 1/00", co, s); end
      do_op8(8'hFF, 8'hFF, 1'b1, s, co, lat, bc);
      n_cmp++;
      if ({co, s} !== 9'h1FF) begin n_bad++; $display("FAIL max_ffff1 got=%b/%h want 1/ff", co, s); end
   endtask

   task automatic test_random;
      logic [7:0] s, ra, rb; logic co, rc; int lat, bc;
      logic [8:0] model;
      for (int i = 0; i < 16; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         model = 9'(ra) + 9'(rb) + 9'(rc);
         do_op8(ra, rb, rc, s, co, lat, bc);
         n_cmp++;
         if ({co, s} !== model || lat !== 8) begin
            n_bad++;
            $display("FAIL random_%0d %h+%h+%b got=%b/%h lat=%0d want %b/%h lat=8",
                     i, ra, rb, rc, co, s, lat, model[8], model[7:0]);
         end
      end
   endtask

   task automatic test_ignore_start;
      int pulses = 0;
      logic [7:0] first_sum = 8'h00; logic first_co = 1'b0;
      @(negedge clk);
      s8_a = 8'h3C; s8_b = 8'h5A; s8_cin = 1'b1; s8_start = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (k == 1) s8_start = 1'b0;
         if (k == 3) begin s8_start = 1'b1; s8_a = 8'hFF; s8_b = 8'hFF; s8_cin = 1'b1; end
         if (k == 4) s8_start = 1'b0;
         if (s8_done) begin
            if (pulses == 0) begin first_sum = s8_sum; first_co = s8_cout; end
            pulses++;
         end
      end
      n_cmp++;
      if (pulses !== 1) begin n_bad++; $display("FAIL ignore_pulses got=%0d want 1", pulses); end
      n_cmp++;
      if ({first_co, first_sum} !== 9'h097) begin
         n_bad++; $display("FAIL ignore_result got=%b/%h want 0/97", first_co, first_sum);
      end
   endtask

   task automatic test_reset_mid_run;
      logic [7:0] s; logic co; int lat, bc;
      int pulses = 0;
      do_op8(8'h12, 8'h34, 1'b0, s, co, lat, bc);
      @(negedge clk);
      s8_a = 8'hA5; s8_b = 8'h5A; s8_cin = 1'b1; s8_start = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (k == 1) s8_start = 1'b0;
         if (k == 4) rst = 1'b1;
         if (k == 5) begin
            rst = 1'b0;
            n_cmp++;
            if ({s8_busy, s8_done, s8_cout, s8_sum} !== 11'h000) begin
               n_bad++;
               $display("FAIL midrst_clear busy/done/cout/sum got=%b/%b/%b/%h want 0/0/0/00",
                        s8_busy, s8_done, s8_cout, s8_sum);
            end
         end
         if (s8_done) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin n_bad++; $display("FAIL midrst_no_done got=%0d pulses want 0", pulses); end
      do_op8(8'h55, 8'hAA, 1'b0, s, co, lat, bc);
      n_cmp++;
      if ({co, s} !== 9'h0FF || lat !== 8) begin
         n_bad++; $display("FAIL midrst_fresh got=%b/%h lat=%0d want 0/ff lat=8", co, s, lat);
      end
   endtask

   task automatic test_back_to_back;
      int pulses = 0;
      int prev = 0;
      @(negedge clk);
      s8_a = 8'h80; s8_b = 8'h80; s8_cin = 1'b0; s8_start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (s8_done) begin
            n_cmp++;
            if ({s8_cout, s8_sum} !== 9'h100) begin
               n_bad++; $display("FAIL b2b_result_%0d got=%b/%h want 1/00", pulses, s8_cout, s8_sum);
            end
            if (prev > 0) begin
               n_cmp++;
               if (k - prev !== 9) begin
                  n_bad++; $display("FAIL b2b_spacing_%0d got=%0d want 9", pulses, k - prev);
               end
            end
            prev = k;
            pulses++;
         end
      end
      s8_start = 1'b0;
      n_cmp++;
      if (pulses !== 4) begin n_bad++; $display("FAIL b2b_pulses got=%0d want 4", pulses); end
      repeat (12) @(negedge clk);
   endtask

   task automatic test_width1;
      logic s, co; int lat, bc;
      logic [1:0] model;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         model = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
         do_op1(v[2], v[1], v[0], s, co, lat, bc);
         n_cmp++;
         if ({co, s} !== model || lat !== 1 || bc !== 1) begin
            n_bad++;
            $display("FAIL w1_%0d %b+%b+%b got=%b/%b lat=%0d busy=%0d want %b/%b lat=1 busy=1",
                     i, v[2], v[1], v[0], co, s, lat, bc, model[1], model[0]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_carry_edges;
      test_random;
      test_ignore_start;
      test_reset_mid_run;
      test_back_to_back;
      test_width1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
